band_mixer: RTL and testbench

//  Output stage of the vocoder, directly downstream of the filterbank. Per frame it takes N_FILTERS band-passed

---
 rtl/band_mixer.sv | 155 +++++++++++++++
 tb/tb_band_mixer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_mixer.sv
// Vocoder output stage: one time-multiplexed MAC mixes carrier*envelope*gain over all bands,
// then scales and saturates to one signed 32-bit sample per frame.
//   state    | meaning
//   ST_IDLE  | ready for a frame; valid_in latches the band arrays
//   ST_MAC   | accumulate one band per cycle, idx 0..N_FILTERS-1
//   ST_SAT   | shift, clip and register the output sample
module band_mixer #(
    parameter int N_FILTERS = 9,
    parameter int ENV_FRAC  = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          valid_in,
    input  logic [N_FILTERS-1:0][31:0]    carrier_in,
    input  logic [N_FILTERS-1:0][31:0]    envelope_in,
    input  logic [N_FILTERS-1:0][7:0]     band_gain_in,
    output logic                          ready_out,
    output logic [31:0]                   sample_out,
    output logic                          valid_out,
    output logic                          sat_out,
    output logic                          overrun_out
);

    localparam int IDX_W = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FILTERS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    localparam logic signed [71:0] S32_MAX = 72'sd2147483647;
    localparam logic signed [71:0] S32_MIN = -72'sd2147483648;

    logic [1:0]                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic signed [71:0]               acc_q, acc_d;
    logic [N_FILTERS-1:0][31:0]       car_q, car_d;
    logic [N_FILTERS-1:0][31:0]       env_q, env_d;
    logic [N_FILTERS-1:0][7:0]        gain_q, gain_d;
    logic [31:0]                      sample_q, sample_d;
    logic                             sat_q, sat_d;
    logic                             valid_q, valid_d;
    logic                             ovr_q, ovr_d;

    logic signed [31:0]               car_sel;
    logic signed [31:0]               env_sel;
    logic signed [63:0]               car_ext;
    logic signed [63:0]               env_pos;
    logic signed [63:0]               prod;
    logic signed [63:0]               prod_sh;
    logic signed [71:0]               prod_sh_ext;
    logic signed [71:0]               gain_ext;
    logic signed [71:0]               scaled;
    logic signed [71:0]               term;
    logic signed [71:0]               acc_sh;

    // Band term for the current index; negative envelopes mute the band.
    always_comb begin
        car_sel     = car_q[idx_q];
        env_sel     = env_q[idx_q];
        car_ext     = {{32{car_sel[31]}}, car_sel};
        env_pos     = env_sel[31] ? 64'sd0 : {32'd0, env_sel};
        prod        = car_ext * env_pos;
        prod_sh     = prod >>> ENV_FRAC;
        prod_sh_ext = {{8{prod_sh[63]}}, prod_sh};
        gain_ext    = {64'd0, gain_q[idx_q]};
        scaled      = prod_sh_ext * gain_ext;
        term        = scaled >>> 7;
        acc_sh      = acc_q >>> OUT_SHIFT;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        car_d    = car_q;
        env_d    = env_q;
        gain_d   = gain_q;
        sample_d = sample_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;
        ovr_d    = ovr_q | (valid_in & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    car_d   = carrier_in;
                    env_d   = envelope_in;
                    gain_d  = band_gain_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + term;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SAT: begin
                if (acc_sh > S32_MAX) begin
                    sample_d = 32'h7FFF_FFFF;
                    sat_d    = 1'b1;
                end else if (acc_sh < S32_MIN) begin
                    sample_d = 32'h8000_0000;
                    sat_d    = 1'b1;
                end else begin
                    sample_d = acc_sh[31:0];
                    sat_d    = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            car_q    <= '0;
            env_q    <= '0;
            gain_q   <= '0;
            sample_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            car_q    <= car_d;
            env_q    <= env_d;
            gain_q   <= gain_d;
            sample_q <= sample_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign ready_out   = (state_q == ST_IDLE);
    assign sample_out  = sample_q;
    assign valid_out   = valid_q;
    assign sat_out     = sat_q;
    assign overrun_out = ovr_q;

endmodule

// File: tb/tb_band_mixer.sv
// Scoreboard bench for band_mixer: directed frames plus randomized frames checked against a
// longint reference of the mixing rules; a negedge monitor pops and compares every output.
module tb_band_mixer;

    localparam int NF = 9;
    localparam int LAT = NF + 2;

    logic                   clk_in;
    logic                   rst_n_in;
    logic                   valid_in;
    logic [NF-1:0][31:0]    carrier_in;
    logic [NF-1:0][31:0]    envelope_in;
    logic [NF-1:0][7:0]     band_gain_in;
    logic                   ready_out;
    logic [31:0]            sample_out;
    logic                   valid_out;
    logic                   sat_out;
    logic                   overrun_out;

    band_mixer #(.N_FILTERS(NF), .ENV_FRAC(16), .OUT_SHIFT(0)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .carrier_in   (carrier_in),
        .envelope_in  (envelope_in),
        .band_gain_in (band_gain_in),
        .ready_out    (ready_out),
        .sample_out   (sample_out),
        .valid_out    (valid_out),
        .sat_out      (sat_out),
        .overrun_out  (overrun_out)
    );

    typedef struct {
        int          cyc;
        logic [31:0] s;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = -1000;
    bit ovr_exp = 0;
    int ovr_from = 0;

    logic [NF-1:0][31:0] t_car;
    logic [NF-1:0][31:0] t_env;
    logic [NF-1:0][7:0]  t_gain;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Mixing rules evaluated directly: clamp, product, two floor shifts, sum, clip.
    function automatic exp_t model(input logic [NF-1:0][31:0] c, input logic [NF-1:0][31:0] e,
                                   input logic [NF-1:0][7:0] g);
        exp_t r;
        longint acc = 0;
        for (int i = 0; i < NF; i++) begin
            longint ci = longint'($signed(c[i]));
            longint ei = longint'($signed(e[i]));
            longint p;
            if (ei < 0) ei = 0;
            p = (ci * ei) >>> 16;
            p = (p * longint'(g[i])) >>> 7;
            acc += p;
        end
        r.cyc = 0;
        if (acc > 64'sd2147483647) begin
            r.s = 32'h7FFF_FFFF; r.sat = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            r.s = 32'h8000_0000; r.sat = 1'b1;
        end else begin
            r.s = acc[31:0]; r.sat = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NF; i++) begin
            carrier_in[i]   = $urandom;
            envelope_in[i]  = $urandom;
            band_gain_in[i] = 8'($urandom);
        end
    endtask

    // Drive t_* for one cycle; the bench decides acceptance from its own frame timing.
    task automatic issue(input bit use_exp, input logic [31:0] xs, input logic xsat);
        exp_t r;
        carrier_in   = t_car;
        envelope_in  = t_env;
        band_gain_in = t_gain;
        valid_in     = 1'b1;
        if (cyc >= last_acc + LAT) begin
            r = model(t_car, t_env, t_gain);
            if (use_exp) begin
                r.s = xs; r.sat = xsat;
            end
            r.cyc = cyc + LAT;
            sb.push_back(r);
            last_acc = cyc;
        end else if (!ovr_exp) begin
            ovr_exp  = 1;
            ovr_from = cyc + 1;
        end
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n_in = 1'b0;
        sb.delete();
        last_acc = -1000;
        ovr_exp  = 0;
        #1;
        chk("rst_sample", sample_out, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'h0);
        chk("rst_sat", {31'd0, sat_out}, 32'h0);
        chk("rst_overrun", {31'd0, overrun_out}, 32'h0);
        chk("rst_ready", {31'd0, ready_out}, 32'h1);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic clear_t();
        t_car = '0; t_env = '0; t_gain = '0;
    endtask

    task automatic set_single(input logic [7:0] g0);
        clear_t();
        t_car[0] = 32'h0001_0000; t_env[0] = 32'h0001_0000; t_gain[0] = g0;
    endtask

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL valid_in_reset: got %b expected 0 (cycle %0d)", valid_out, cyc);
            end
        end else begin
            checks++;
            if (ready_out !== ((cyc > last_acc && cyc < last_acc + LAT) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL ready: got %b (cycle %0d, frame at %0d)", ready_out, cyc, last_acc);
            end
            checks++;
            if (overrun_out !== ((ovr_exp && cyc >= ovr_from) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL overrun: got %b expected %b (cycle %0d)", overrun_out,
                         (ovr_exp && cyc >= ovr_from), cyc);
            end
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got valid_out=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", cyc, mon_e.cyc);
                    chk("sample", sample_out, mon_e.s);
                    chk("sat", {31'd0, sat_out}, {31'd0, mon_e.sat});
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                checks++; errors++;
                $display("FAIL missing_valid: got none expected sample %h at cycle %0d", mon_e.s, mon_e.cyc);
            end
        end
    end

    initial begin
        rst_n_in = 1'b1;
        valid_in = 1'b0;
        carrier_in = '0; envelope_in = '0; band_gain_in = '0;
        clear_t();
        do_reset();
        wait_cycles(2);

        set_single(8'd128);
        issue(1, 32'h0001_0000, 1'b0);
        wait_cycles(LAT - 1);
        set_single(8'd64);
        issue(1, 32'h0000_8000, 1'b0);
        wait_cycles(LAT + 2);

        for (int i = 0; i < NF; i++) begin
            t_car[i] = 32'h7FFF_FFFF; t_env[i] = 32'h7FFF_FFFF; t_gain[i] = 8'd255;
        end
        issue(1, 32'h7FFF_FFFF, 1'b1);
        wait_cycles(LAT + 1);
        for (int i = 0; i < NF; i++) t_car[i] = 32'h8000_0000;
        issue(1, 32'h8000_0000, 1'b1);
        wait_cycles(LAT + 1);

        for (int i = 0; i < NF; i++) begin
            t_car[i] = 32'h0001_0000; t_env[i] = 32'h0001_0000; t_gain[i] = 8'd128;
        end
        t_env[2] = -32'sd5;
        t_gain[5] = 8'd0;
        issue(1, 32'h0007_0000, 1'b0);
        wait_cycles(LAT + 1);

        set_single(8'd128);
        issue(1, 32'h0001_0000, 1'b0);
        wait_cycles(3);
        set_single(8'd64);
        t_car[3] = 32'h0123_4567; t_env[3] = 32'h0002_0000; t_gain[3] = 8'd200;
        issue(0, 32'h0, 1'b0);
        chk("overrun_set", {31'd0, overrun_out}, 32'h1);
        wait_cycles(LAT + 3);

        set_single(8'd128);
        t_car[1] = 32'h0300_0000; t_env[1] = 32'h0001_8000; t_gain[1] = 8'd77;
        issue(0, 32'h0, 1'b0);
        wait_cycles(4);
        do_reset();
        chk("ready_after_reset", {31'd0, ready_out}, 32'h1);
        set_single(8'd128);
        issue(1, 32'h0001_0000, 1'b0);
        wait_cycles(LAT + 1);

        for (int n = 0; n < 40; n++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NF; i++) begin
                if (wide) begin
                    t_car[i] = $urandom; t_env[i] = $urandom;
                end else begin
                    t_car[i] = 32'($signed($urandom_range(0, 2097151)) - 1048576);
                    t_env[i] = 32'($signed($urandom_range(0, 262143)) - 65536);
                end
                t_gain[i] = 8'($urandom);
            end
            issue(0, 32'h0, 1'b0);
            wait_cycles($urandom_range(8, 13));
        end
        wait_cycles(LAT + 4);

        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++; errors++;
            $display("FAIL leftover: got no output expected sample %h at cycle %0d", mon_e.s, mon_e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
